// File: rtl/pwm_multi_pkg.sv
// Shared register map and bit positions for the multi-channel PWM controller.
package pwm_multi_pkg;

    typedef enum logic [1:0] {
        REG_PERIOD = 2'd0,
        REG_DUTY   = 2'd1,
        REG_CTRL   = 2'd2,
        REG_STATUS = 2'd3
    } reg_sel_e;

    localparam int unsigned CTRL_EN     = 0;
    localparam int unsigned CTRL_POL    = 1;
    localparam int unsigned STATUS_PEND = 0;

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: shadow/active period and duty, free-running counter, output flops.
module pwm_channel #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_period,
    input  logic             wr_duty,
    input  logic             wr_ctrl,
    input  logic [CNT_W-1:0] wdata,
    output logic [CNT_W-1:0] shadow_period,
    output logic [CNT_W-1:0] shadow_duty,
    output logic             en,
    output logic             pol,
    output logic             pend,
    output logic             pwm_out,
    output logic             period_tick
);
    import pwm_multi_pkg::*;

    logic [CNT_W-1:0] act_period;
    logic [CNT_W-1:0] act_duty;
    logic [CNT_W-1:0] cnt;
    logic             pend_q;
    logic             shadow_wr;
    logic             wrap;
    logic             raw;

    assign shadow_wr = wr_period | wr_duty;
    assign wrap      = en && (act_period != '0) && (cnt == act_period - CNT_W'(1));
    assign raw       = (act_period != '0) && (cnt < act_duty);
    assign pend      = pend_q & en;

    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_period <= '0;
            shadow_duty   <= '0;
            act_period    <= '0;
            act_duty      <= '0;
            cnt           <= '0;
            en            <= 1'b0;
            pol           <= 1'b0;
            pend_q        <= 1'b0;
            pwm_out       <= 1'b0;
            period_tick   <= 1'b0;
        end else begin
            if (wr_period) shadow_period <= wdata;
            if (wr_duty)   shadow_duty   <= wdata;
            if (wr_ctrl) begin
                en  <= wdata[CTRL_EN];
                pol <= wdata[CTRL_POL];
            end

            pwm_out     <= pol ^ (en & raw);
            period_tick <= wrap;

            // Transfers sample the shadow before this cycle's write lands.
            if (!en) begin
                act_period <= shadow_period;
                act_duty   <= shadow_duty;
                pend_q     <= 1'b0;
                cnt        <= '0;
            end else if (wrap) begin
                act_period <= shadow_period;
                act_duty   <= shadow_duty;
                pend_q     <= shadow_wr;
                cnt        <= '0;
            end else begin
                if (shadow_wr) pend_q <= 1'b1;
                cnt <= (act_period == '0) ? '0 : cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/pwm_multi_ctrl.sv
// Avalon-MM front end: address decode and read mux over N_CH independent PWM channels.
module pwm_multi_ctrl #(
    parameter  int N_CH  = 4,
    parameter  int CNT_W = 16,
    localparam int CH_AW = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [CH_AW+1:0] address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [N_CH-1:0]  pwm_out,
    output logic [N_CH-1:0]  period_tick
);
    import pwm_multi_pkg::*;

    reg_sel_e         reg_sel;
    logic [CH_AW-1:0] ch_sel;
    logic             wr;
    logic             unused_wdata;

    logic [CNT_W-1:0] shadow_period [N_CH];
    logic [CNT_W-1:0] shadow_duty   [N_CH];
    logic [N_CH-1:0]  en;
    logic [N_CH-1:0]  pol;
    logic [N_CH-1:0]  pend;

    assign reg_sel      = reg_sel_e'(address[1:0]);
    assign ch_sel       = address[CH_AW+1:2];
    assign wr           = chipselect & ~write_n;
    assign unused_wdata = ^writedata;

    // Channel numbers at or above N_CH match no instance, so such writes drop.
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic hit;
        assign hit = wr && (ch_sel == CH_AW'(i));

        pwm_channel #(.CNT_W(CNT_W)) u_ch (
            .clk          (clk),
            .reset        (reset),
            .wr_period    (hit && (reg_sel == REG_PERIOD)),
            .wr_duty      (hit && (reg_sel == REG_DUTY)),
            .wr_ctrl      (hit && (reg_sel == REG_CTRL)),
            .wdata        (writedata[CNT_W-1:0]),
            .shadow_period(shadow_period[i]),
            .shadow_duty  (shadow_duty[i]),
            .en           (en[i]),
            .pol          (pol[i]),
            .pend         (pend[i]),
            .pwm_out      (pwm_out[i]),
            .period_tick  (period_tick[i])
        );
    end

    always_comb begin
        readdata = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (ch_sel == CH_AW'(i)) begin
                case (reg_sel)
                    REG_PERIOD: readdata = 32'(shadow_period[i]);
                    REG_DUTY:   readdata = 32'(shadow_duty[i]);
                    REG_CTRL: begin
                        readdata[CTRL_EN]  = en[i];
                        readdata[CTRL_POL] = pol[i];
                    end
                    REG_STATUS: readdata[STATUS_PEND] = pend[i];
                    default:    readdata = '0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pwm_multi_ctrl.sv
// Self-checking bench for pwm_multi_ctrl: rule-based channel model, register tables, directed corner sequences.
module tb_pwm_multi_ctrl;

    typedef struct {
        logic [3:0]  addr;
        logic [31:0] exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  address = '0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic [3:0]  pwm_out;
    logic [3:0]  period_tick;

    logic [3:0]  b_address = '0;
    logic        b_chipselect = 1'b0;
    logic        b_write_n = 1'b1;
    logic [31:0] b_writedata = '0;
    logic [31:0] b_readdata;
    logic [2:0]  b_pwm_out;
    logic [2:0]  b_period_tick;

    int ntests = 0;
    int nfail  = 0;

    // Reference state: what each channel holds according to the register rules.
    logic [15:0] m_sp [4];
    logic [15:0] m_sd [4];
    logic [15:0] m_ap [4];
    logic [15:0] m_ad [4];
    logic [15:0] m_pos [4];
    logic [3:0]  m_en, m_pol, m_pend, m_pwm, m_tick;

    pwm_multi_ctrl #(.N_CH(4), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata),
        .pwm_out(pwm_out), .period_tick(period_tick)
    );

    pwm_multi_ctrl #(.N_CH(3), .CNT_W(16)) dut3 (
        .clk(clk), .reset(reset), .address(b_address), .chipselect(b_chipselect),
        .write_n(b_write_n), .writedata(b_writedata), .readdata(b_readdata),
        .pwm_out(b_pwm_out), .period_tick(b_period_tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Advance the model by one clock, using the bus inputs as they stand at the edge.
    task automatic model_step();
        for (int c = 0; c < 4; c++) begin
            logic sel, shadow_write, end_of_period;
            sel           = chipselect && !write_n && (address[3:2] == c[1:0]);
            shadow_write  = sel && (address[1:0] < 2'd2);
            end_of_period = m_en[c] && (m_ap[c] != 0) && (int'(m_pos[c]) + 1 == int'(m_ap[c]));
            if (reset) begin
                m_sp[c] = 0; m_sd[c] = 0; m_ap[c] = 0; m_ad[c] = 0; m_pos[c] = 0;
                m_en[c] = 0; m_pol[c] = 0; m_pend[c] = 0; m_pwm[c] = 0; m_tick[c] = 0;
            end else begin
                m_pwm[c]  = m_pol[c] ^ (m_en[c] && m_ap[c] != 0 && m_pos[c] < m_ad[c]);
                m_tick[c] = end_of_period;
                if (!m_en[c] || end_of_period) begin
                    m_ap[c]   = m_sp[c];
                    m_ad[c]   = m_sd[c];
                    m_pos[c]  = 0;
                    m_pend[c] = m_en[c] && shadow_write;
                end else begin
                    m_pend[c] = m_pend[c] | shadow_write;
                    m_pos[c]  = (m_ap[c] == 0) ? 16'd0 : 16'((int'(m_pos[c]) + 1) % int'(m_ap[c]));
                end
                if (sel) begin
                    case (address[1:0])
                        2'd0: m_sp[c] = writedata[15:0];
                        2'd1: m_sd[c] = writedata[15:0];
                        2'd2: {m_pol[c], m_en[c]} = writedata[1:0];
                        default: ;
                    endcase
                end
            end
        end
    endtask

    function automatic logic [31:0] model_read(input logic [3:0] a);
        int c;
        c = int'(a[3:2]);
        case (a[1:0])
            2'd0: return {16'd0, m_sp[c]};
            2'd1: return {16'd0, m_sd[c]};
            2'd2: return {30'd0, m_pol[c], m_en[c]};
            default: return {31'd0, m_pend[c] & m_en[c]};
        endcase
    endfunction

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("pwm_out", {28'd0, pwm_out}, {28'd0, m_pwm});
        chk("period_tick", {28'd0, period_tick}, {28'd0, m_tick});
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        cycle();
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic b_wr(input logic [3:0] a, input logic [31:0] d);
        b_address = a; b_writedata = d; b_chipselect = 1'b1; b_write_n = 1'b0;
        cycle();
        b_chipselect = 1'b0; b_write_n = 1'b1;
    endtask

    task automatic rd_chk(input string nm, input logic [3:0] a, input logic [31:0] e);
        address = a;
        #1;
        chk(nm, readdata, e);
    endtask

    task automatic wait_tick(input int ch, input int lim, input string nm);
        int n = 0;
        do begin
            cycle();
            n++;
        end while (!period_tick[ch] && n < lim);
        chk(nm, {31'd0, period_tick[ch]}, 32'd1);
    endtask

    vec_t cfg_tbl [9];
    vec_t b_tbl [9];

    initial begin
        cfg_tbl[0] = '{4'h0, 32'h12};  cfg_tbl[1] = '{4'h1, 32'h7};
        cfg_tbl[2] = '{4'h2, 32'h0};   cfg_tbl[3] = '{4'h3, 32'h0};
        cfg_tbl[4] = '{4'h6, 32'h2};   cfg_tbl[5] = '{4'h7, 32'h0};
        cfg_tbl[6] = '{4'h9, 32'hFF};  cfg_tbl[7] = '{4'hB, 32'h0};
        cfg_tbl[8] = '{4'h8, 32'h0};
        b_tbl[0] = '{4'hC, 32'h0}; b_tbl[1] = '{4'hD, 32'h0};
        b_tbl[2] = '{4'hE, 32'h0}; b_tbl[3] = '{4'hF, 32'h0};
        b_tbl[4] = '{4'h0, 32'h9}; b_tbl[5] = '{4'h9, 32'h5};
        b_tbl[6] = '{4'h2, 32'h0}; b_tbl[7] = '{4'hA, 32'h0};
        b_tbl[8] = '{4'h1, 32'h0};

        reset = 1'b1;
        cycle();
        cycle();
        reset = 1'b0;
        for (int i = 0; i < 16; i++) rd_chk("reset_read", 4'(i), 32'd0);

        // Register map with channels disabled: masking, CTRL width, read-only STATUS.
        wr(4'h0, 32'hABCD_0012);
        wr(4'h1, 32'h0000_0007);
        wr(4'h2, 32'hFFFF_FFFC);
        wr(4'h6, 32'h0000_0006);
        wr(4'hB, 32'h0000_0005);
        wr(4'h9, 32'h1234_00FF);
        for (int i = 0; i < 9; i++) rd_chk("cfg_read", cfg_tbl[i].addr, cfg_tbl[i].exp);
        chk("pol_idle", {31'd0, pwm_out[1]}, 32'd1);

        reset = 1'b1;
        cycle();
        reset = 1'b0;

        // ch0: 3 high / 7 low, tick every 10.
        wr(4'h0, 32'd10); wr(4'h1, 32'd3); wr(4'h2, 32'd1);
        wait_tick(0, 30, "ch0_first_tick");
        for (int k = 1; k <= 20; k++) begin
            cycle();
            chk("ch0_pwm", {31'd0, pwm_out[0]}, {31'd0, ((k - 1) % 10) < 3});
            chk("ch0_tick", {31'd0, period_tick[0]}, {31'd0, (k % 10) == 0});
        end

        // ch1: duty change mid-period is deferred to the next period.
        wr(4'h4, 32'd8); wr(4'h5, 32'd2); wr(4'h6, 32'd1);
        wait_tick(1, 20, "ch1_first_tick");
        cycle(); cycle(); cycle();
        wr(4'h5, 32'd6);
        rd_chk("ch1_pend_set", 4'h7, 32'd1);
        for (int k = 5; k <= 16; k++) begin
            cycle();
            chk("ch1_pwm", {31'd0, pwm_out[1]},
                {31'd0, (k <= 8) ? (((k - 1) % 8) < 2) : (((k - 1) % 8) < 6)});
            chk("ch1_tick", {31'd0, period_tick[1]}, {31'd0, (k == 8) || (k == 16)});
            if (k == 8) rd_chk("ch1_pend_clr", 4'h7, 32'd0);
        end

        // ch2: inverted 0% and inverted 100%.
        wr(4'h8, 32'd16); wr(4'h9, 32'd0); wr(4'hA, 32'd3);
        for (int k = 0; k < 20; k++) begin
            cycle();
            chk("ch2_inv0", {31'd0, pwm_out[2]}, 32'd1);
        end
        wr(4'h9, 32'd20);
        repeat (20) cycle();
        for (int k = 0; k < 20; k++) begin
            cycle();
            chk("ch2_inv100", {31'd0, pwm_out[2]}, 32'd0);
        end

        // ch3: P=0 never wraps, so a new period waits for an EN toggle.
        wr(4'hC, 32'd0); wr(4'hE, 32'd1);
        for (int k = 0; k < 12; k++) begin
            cycle();
            chk("ch3_p0_pwm", {31'd0, pwm_out[3]}, 32'd0);
            chk("ch3_p0_tick", {31'd0, period_tick[3]}, 32'd0);
        end
        wr(4'hC, 32'd4);
        rd_chk("ch3_pend", 4'hF, 32'd1);
        repeat (10) cycle();
        rd_chk("ch3_pend_hold", 4'hF, 32'd1);
        chk("ch3_still_idle", {31'd0, pwm_out[3]}, 32'd0);
        wr(4'hE, 32'd0);
        rd_chk("ch3_pend_dis", 4'hF, 32'd0);
        wr(4'hE, 32'd1);
        wait_tick(3, 12, "ch3_tick_after_toggle");

        // Random bus traffic against the model.
        for (int n = 0; n < 1500; n++) begin
            logic [3:0] a;
            a = 4'($urandom_range(0, 15));
            address    = a;
            chipselect = ($urandom_range(0, 3) != 0);
            write_n    = ($urandom_range(0, 2) != 0);
            case (a[1:0])
                2'd0: writedata = {16'($urandom), 16'($urandom_range(0, 12))};
                2'd1: writedata = {16'($urandom), 16'($urandom_range(0, 14))};
                default: writedata = $urandom;
            endcase
            reset = (n == 700);
            #1;
            chk("rand_read", readdata, model_read(a));
            cycle();
        end
        chipselect = 1'b0; write_n = 1'b1; reset = 1'b0;

        // Reset in the middle of running periods.
        wr(4'h0, 32'd10); wr(4'h1, 32'd3); wr(4'h2, 32'd1);
        wr(4'h4, 32'd5);  wr(4'h5, 32'd4); wr(4'h6, 32'd3);
        repeat (4) cycle();
        reset = 1'b1;
        cycle();
        chk("rst_pwm", {28'd0, pwm_out}, 32'd0);
        chk("rst_tick", {28'd0, period_tick}, 32'd0);
        for (int i = 0; i < 16; i++) rd_chk("rst_read", 4'(i), 32'd0);
        reset = 1'b0;
        cycle();
        chk("post_rst_tick", {28'd0, period_tick}, 32'd0);
        chk("post_rst_pwm", {28'd0, pwm_out}, 32'd0);

        // Three-channel instance: channel 3 is unmapped.
        b_wr(4'h0, 32'd9);
        b_wr(4'h9, 32'd5);
        b_wr(4'hC, 32'h77);
        b_wr(4'hE, 32'd3);
        b_wr(4'hD, 32'd5);
        repeat (3) cycle();
        for (int i = 0; i < 9; i++) begin
            b_address = b_tbl[i].addr;
            #1;
            chk("n3_read", b_readdata, b_tbl[i].exp);
        end
        chk("n3_pwm", {29'd0, b_pwm_out}, 32'd0);
        chk("n3_tick", {29'd0, b_period_tick}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
